// File: rtl/edlo_pkg.sv
// -----------------------------------------------------------------------------
// edlo_pkg
// Shared definitions for the edlo execution core.
//   - 4-bit opcode encodings OP_NOP .. OP_RSVD
//   - state_t: execution core sequencing states (ST_IDLE, ST_MUL)
// -----------------------------------------------------------------------------
package edlo_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_READ = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_LDA  = 4'hA;
  localparam logic [3:0] OP_STA  = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_OUTA = 4'hE;
  localparam logic [3:0] OP_RSVD = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/edlo_mul_seq.sv
// -----------------------------------------------------------------------------
// edlo_mul_seq
// Unsigned shift-add multiplier, one partial product per clock.
// Bit 0 of the multiplier is folded in on the start edge, the remaining
// DATA_W-1 bits on the following edges, so done is high in the cycle that
// ends DATA_W edges after start and product is final while done is high.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (aborts a multiply)
//   start    in   latch a and b and begin a multiply
//   a, b     in   DATA_W-bit operands
//   done     out  product is complete (one cycle)
//   product  out  2*DATA_W-bit result
// -----------------------------------------------------------------------------
module edlo_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  // Holds DATA_W-1 for any DATA_W >= 2.
  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] r_mcand;
  logic [2*DATA_W-1:0] r_prod;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_run;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{DATA_W{1'b0}}, a} << 1;
      r_mplier <= b >> 1;
      r_prod   <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
      r_cnt    <= CNT_W'(DATA_W - 1);
      r_run    <= 1'b1;
    end else if (r_run) begin
      // r_cnt counts partial products still to add; at zero the result is
      // being consumed this cycle and the unit goes idle.
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign done    = r_run && (r_cnt == '0);
  assign product = r_prod;

endmodule

// File: rtl/edlo_exec_core.sv
// -----------------------------------------------------------------------------
// edlo_exec_core
// Accumulator execution core: ALU, 2**ADDR_BITS-word scratch memory, flags and
// an instruction valid/ready handshake.
// Build option: define EDLO_MUL_EN to build the multi-cycle multiply (opcode D).
// Without it, opcode D is reserved, busy is 0 and inst_ready is always 1.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   inst        in   4-bit opcode
//   addr        in   memory word address
//   data_in     in   immediate / load data
//   inst_valid  in   inst/addr/data_in valid
//   inst_ready  out  core accepts an instruction this cycle
//   data_out    out  registered READ / OUTA result
//   out_valid   out  one-cycle pulse when data_out updates
//   busy        out  multiply in progress
//   carry       out  carry / borrow flag
//   zero        out  accumulator == 0
//   illegal     out  sticky reserved-opcode flag
// -----------------------------------------------------------------------------
module edlo_exec_core
  import edlo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           inst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 carry,
  output logic                 zero,
  output logic                 illegal
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_data_out;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_carry;
  logic              r_illegal;
  logic              r_out_valid;

  logic              w_inst_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_m;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;

  assign w_accept = inst_valid & w_inst_ready;
  assign w_m      = r_mem[addr];
  // The extra top bit is the carry out of ADD and the borrow out of SUB.
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_m};
  assign w_diff   = {1'b0, r_acc} - {1'b0, w_m};

`ifdef EDLO_MUL_EN
  state_t              r_state;
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_product;

  assign w_inst_ready = (r_state == ST_IDLE);
  assign busy         = (r_state == ST_MUL);
  // Operands are captured by the multiplier on the accept edge, so the
  // accumulator and memory may be left untouched while it runs.
  assign w_mul_start  = w_accept && (inst == OP_MUL);

  edlo_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (r_acc),
    .b       (w_m),
    .done    (w_mul_done),
    .product (w_product)
  );
`else
  assign w_inst_ready = 1'b1;
  assign busy         = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc       <= '0;
      r_data_out  <= '0;
      r_carry     <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      // NOTE: the scratch memory is a flop array that must read as zero after
      // reset, so every word is cleared here; a RAM macro could not do this.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
`ifdef EDLO_MUL_EN
      r_state     <= ST_IDLE;
`endif
    end else begin
      // NOTE: default-low with a later override makes out_valid a one-cycle
      // pulse; with non-blocking assignments the last write in the block wins.
      r_out_valid <= 1'b0;

      if (w_accept) begin
        case (inst)
          OP_NOP:  ;
          OP_LOAD: r_mem[addr] <= data_in;
          OP_READ: begin
            r_data_out  <= w_m;
            r_out_valid <= 1'b1;
          end
          OP_ADD:  {r_carry, r_acc} <= w_sum;
          OP_SUB:  {r_carry, r_acc} <= w_diff;
          OP_AND:  r_acc <= r_acc & w_m;
          OP_OR:   r_acc <= r_acc | w_m;
          OP_XOR:  r_acc <= r_acc ^ w_m;
          OP_SHL: begin
            r_carry <= r_acc[DATA_W-1];
            r_acc   <= r_acc << 1;
          end
          OP_SHR: begin
            r_carry <= r_acc[0];
            r_acc   <= r_acc >> 1;
          end
          OP_LDA:  r_acc <= data_in;
          OP_STA:  r_mem[addr] <= r_acc;
          OP_CLR: begin
            r_acc   <= '0;
            r_carry <= 1'b0;
          end
          OP_OUTA: begin
            r_data_out  <= r_acc;
            r_out_valid <= 1'b1;
          end
`ifdef EDLO_MUL_EN
          OP_MUL:  r_state   <= ST_MUL;
          OP_RSVD: r_illegal <= 1'b1;
`else
          OP_MUL, OP_RSVD: r_illegal <= 1'b1;
`endif
          default: ;
        endcase
      end

`ifdef EDLO_MUL_EN
      // Result lands on the same edge that returns the core to IDLE.
      if ((r_state == ST_MUL) && w_mul_done) begin
        r_acc   <= w_product[DATA_W-1:0];
        r_carry <= |w_product[2*DATA_W-1:DATA_W];
        r_state <= ST_IDLE;
      end
`endif
    end
  end

  assign inst_ready = w_inst_ready;
  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign carry      = r_carry;
  assign zero       = (r_acc == '0);
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_edlo_exec_core.sv
// -----------------------------------------------------------------------------
// tb_edlo_exec_core
// Self-checking bench for edlo_exec_core (default parameters). Works with and
// without EDLO_MUL_EN defined. A reference model applies each accepted
// instruction with plain integer arithmetic; READ/OUTA results go into a
// queue that a negedge monitor drains whenever out_valid is high.
// -----------------------------------------------------------------------------
module tb_edlo_exec_core;
  import edlo_pkg::*;

  localparam int DATA_W    = 8;
  localparam int ADDR_BITS = 4;
  localparam int DEPTH     = 16;
  localparam int MASK      = 255;
  localparam int WAIT_MAX  = 50;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [3:0]           inst = 4'h0;
  logic [ADDR_BITS-1:0] addr = '0;
  logic [DATA_W-1:0]    data_in = '0;
  logic                 inst_valid = 1'b0;
  logic                 inst_ready;
  logic [DATA_W-1:0]    data_out;
  logic                 out_valid;
  logic                 busy;
  logic                 carry;
  logic                 zero;
  logic                 illegal;

  always #5 clock = ~clock;

  edlo_exec_core #(
    .DATA_W    (DATA_W),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .addr       (addr),
    .data_in    (data_in),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .carry      (carry),
    .zero       (zero),
    .illegal    (illegal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_acc;
  int m_carry;
  int m_illegal;
  int m_mem [DEPTH];
  int m_mul_pending;
  int exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc         = 0;
    m_carry       = 0;
    m_illegal     = 0;
    m_mul_pending = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_apply(input int op, input int a, input int d);
    int m;
    int p;
    m = m_mem[a];
    m_mul_pending = 0;
    case (op)
      1:  m_mem[a] = d;
      2:  exp_q.push_back(m);
      3:  begin p = m_acc + m; m_carry = (p > MASK) ? 1 : 0; m_acc = p % 256; end
      4:  begin m_carry = (m_acc < m) ? 1 : 0; m_acc = (m_acc - m + 256) % 256; end
      5:  m_acc = m_acc & m;
      6:  m_acc = m_acc | m;
      7:  m_acc = m_acc ^ m;
      8:  begin m_carry = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; end
      9:  begin m_carry = m_acc % 2; m_acc = m_acc / 2; end
      10: m_acc = d;
      11: m_mem[a] = m_acc;
      12: begin m_acc = 0; m_carry = 0; end
      13: begin
`ifdef EDLO_MUL_EN
        p = m_acc * m;
        m_acc = p % 256;
        m_carry = (p / 256 != 0) ? 1 : 0;
        m_mul_pending = 1;
`else
        m_illegal = 1;
`endif
      end
      14: exp_q.push_back(m_acc);
      15: m_illegal = 1;
      default: ;
    endcase
  endfunction

  // Drive one instruction, holding inst_valid until the core is ready.
  // Before the accept edge the flags are compared against the model state
  // left by all earlier instructions.
  task automatic issue(input int op, input int a, input int d);
    int waited;
    int exp_wait;
    waited   = 0;
    exp_wait = (m_mul_pending != 0) ? DATA_W : 0;
    @(negedge clock);
    inst       = 4'(op);
    addr       = ADDR_BITS'(a);
    data_in    = DATA_W'(d);
    inst_valid = 1'b1;
    while (!inst_ready && waited < WAIT_MAX) begin
      @(negedge clock);
      waited++;
    end
    check("ready_wait_cycles", 32'(waited), 32'(exp_wait));
    check("carry", 32'(carry), 32'(m_carry));
    check("zero", 32'(zero), (m_acc == 0) ? 32'd1 : 32'd0);
    check("illegal", 32'(illegal), 32'(m_illegal));
    check("busy_when_ready", 32'(busy), 32'd0);
    if (waited >= WAIT_MAX) begin
      inst_valid = 1'b0;
      return;
    end
    @(posedge clock);
    model_apply(op, a, d);
    #1 inst_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    inst_valid = 1'b0;
    @(posedge clock);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_inst_ready", 32'(inst_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest result.
  always @(negedge clock) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_valid_unexpected: data_out 0x%0h with no result pending (t=%0t)",
                 data_out, $time);
      end else begin
        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    int a;
    int d;
    model_reset();
    do_reset();

    // Load / read back, then a NOP so a stretched pulse would be caught.
    issue(1, 3, 'h5A);
    issue(2, 3, 0);
    issue(0, 0, 0);

    // ADD with carry out, SUB with borrow.
    issue(10, 0, 'hF0);
    issue(1, 1, 'h20);
    issue(3, 1, 0);
    issue(14, 0, 0);
    issue(4, 1, 0);
    issue(14, 0, 0);

    // Shifts down to zero.
    issue(10, 0, 'h81);
    issue(8, 0, 0);
    issue(14, 0, 0);
    issue(9, 0, 0);
    issue(9, 0, 0);
    issue(14, 0, 0);

    // STA then immediate READ of the same address.
    issue(10, 0, 'hA5);
    issue(11, 7, 0);
    issue(2, 7, 0);

`ifdef EDLO_MUL_EN
    // Multiplies; the following OUTA is held until the core is ready.
    issue(10, 0, 'h0C);
    issue(1, 2, 'h0B);
    issue(13, 2, 0);
    issue(14, 0, 0);
    issue(10, 0, 'h20);
    issue(1, 2, 'h10);
    issue(13, 2, 0);
    issue(14, 0, 0);
    issue(0, 0, 0);

    // Reset in the 4th busy cycle aborts the multiply.
    issue(10, 0, 'h0C);
    issue(1, 2, 'h0B);
    issue(13, 2, 0);
    repeat (4) @(negedge clock);
    check("busy_mid_mul", 32'(busy), 32'd1);
    check("ready_mid_mul", 32'(inst_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(inst_ready), 32'd1);
    check("abort_zero", 32'(zero), 32'd1);
    check("abort_carry", 32'(carry), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    issue(2, 2, 0);
    issue(14, 0, 0);
`endif

    // Reserved opcode and opcode D; illegal must stay set until reset.
    issue(10, 0, 'h33);
    issue(15, 0, 0);
    issue(14, 0, 0);
    issue(1, 4, 'h07);
    issue(13, 4, 0);
    issue(14, 0, 0);
    issue(0, 0, 0);
    do_reset();
    issue(2, 3, 0);

    // Randomised instruction stream with periodic resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 90 == 89) do_reset();
      op = int'($urandom_range(0, 15));
      if (op == 15 && $urandom_range(0, 7) != 0) op = 14;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                      : int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = 0;
        1:       d = MASK;
        default: d = int'($urandom_range(0, MASK));
      endcase
      issue(op, a, d);
    end

    issue(0, 0, 0);
    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edlo_exec_core.md
# edlo_exec_core

Parametrised successor to the 8-bit ALU/memory-controller pair: a single execution core that merges the accumulator ALU, a register-file scratch memory and an instruction handshake into one block. It is generalised in data width and memory depth and adds carry/zero flags, an illegal-opcode flag and a multi-cycle multiply. It sits between the chip pin mux (instruction, address and data in; result out) and nothing else.

## Interface
- DATA_W, 8: datapath, accumulator and memory word width (≥ 4).
- ADDR_BITS, 4: memory address width; depth = 2**ADDR_BITS words.
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- inst  in  4  opcode.
- addr  in  ADDR_BITS  memory word address.
- data_in  in  DATA_W  immediate/load data.
- inst_valid  in  1  inst, addr and data_in are valid this cycle.
- inst_ready  out  1  core accepts an instruction this cycle.
- data_out  out  DATA_W  registered result of READ/OUTA.
- out_valid  out  1  one-cycle pulse: data_out updated.
- busy  out  1  multiply in progress.
- carry  out  1  carry/borrow flag.
- zero  out  1  accumulator == 0 flag.
- illegal  out  1  sticky: reserved opcode accepted.

## Operation
- Accept = inst_valid & inst_ready; inputs are sampled only on accept.
- State machine: IDLE (inst_ready = 1), MUL (inst_ready = 0, busy = 1). IDLE→MUL on accepted MUL; MUL→IDLE after DATA_W iterations.
- Opcodes (acc = accumulator, M = mem[addr]):
  - 0 NOP; 1 LOAD M ← data_in; 2 READ data_out ← M, pulse out_valid.
  - 3 ADD {carry, acc} ← acc + M; 4 SUB {borrow, acc} ← acc − M, where carry = 1 on borrow.
  - 5 AND, 6 OR, 7 XOR acc ← acc op M; carry unchanged.
  - 8 SHL: carry ← acc[MSB], acc ← acc << 1. 9 SHR: carry ← acc[0], acc ← acc >> 1 (logical).
  - A LDA acc ← data_in; B STA M ← acc; C CLR acc ← 0, carry ← 0.
  - D MUL acc ← low DATA_W bits of acc × M (unsigned, shift-add); carry ← 1 if the high half is nonzero.
  - E OUTA data_out ← acc, pulse out_valid.
  - F reserved: sets illegal; no other state changes.
- zero tracks the registered acc at all times (combinational from acc).
- Arithmetic is modulo 2**DATA_W. All addresses are valid; there is no bounds error.
- inst_valid while in MUL is ignored; the issuer must hold it until inst_ready.

## Timing
- Reset values: acc = 0, all memory words = 0, data_out = 0, out_valid = 0, busy = 0, carry = 0, illegal = 0, inst_ready = 1, state = IDLE.
- Single-cycle opcodes: accepted at edge N; results are visible after edge N (acc, M, flags, data_out, out_valid).
- Back-to-back issue in IDLE: a READ of an address written by the previous instruction returns the new value.
- MUL: accepted at edge N. busy and !inst_ready hold for DATA_W cycles. The result lands at edge N+DATA_W, and IDLE is reached in the same cycle. The next accept is possible at edge N+DATA_W+1.
- Operands are latched at accept; memory is not modified during MUL.
- Reset mid-MUL: the multiply is aborted and every register takes its reset value on that edge.
- illegal is cleared only by reset.

## Configuration
- EDLO_MUL_EN defined: opcode D executes MUL as above, and the MUL state and the multiplier sub-module are built.
- Not defined: opcode D is treated as reserved (sets illegal, one cycle). busy is tied 0 and inst_ready is tied 1.

## Structure
- edlo_pkg: opcode localparams (OP_NOP … OP_RSVD), state encoding (ST_IDLE, ST_MUL).
- Sub-module edlo_mul_seq: shift-add multiplier with ports start, a, b, done, product[2*DATA_W-1:0]. Instantiated only under EDLO_MUL_EN.
- Memory is a flop array inside the core; there is no macro RAM.

## Test plan
- Reset, then LOAD addr 3 = 0x5A, READ addr 3 → data_out = 0x5A, out_valid high for exactly one cycle.
- LDA 0xF0, LOAD addr 1 = 0x20, ADD addr 1 → acc = 0x10, carry = 1, zero = 0. Then SUB addr 1 → acc = 0xF0, carry = 1 (borrow).
- LDA 0x81, SHL → acc = 0x02, carry = 1. SHR twice → acc = 0x00, zero = 1.
- With EDLO_MUL_EN: LDA 0x0C, LOAD addr 2 = 0x0B, MUL addr 2 → busy for 8 cycles, then OUTA → 0x84, carry = 0. Repeat with 0x20 × 0x10 → acc = 0x00, carry = 1.
- Assert reset at the 4th cycle of a MUL → next cycle acc = 0, busy = 0, inst_ready = 1. inst_valid held during MUL must be accepted only after busy falls.
- Opcode F → illegal = 1, acc unchanged; illegal stays high until reset. Without EDLO_MUL_EN, opcode D behaves identically.
